fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that produces the PC and instruction words consumed by the IF/ID pipeline register. It sequences the program counter and issues requests to instruction memory through a req/ready handshake. When ID stalls, it buffers one returned instruction. On a branch or jump redirect, it discards wrong-path responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  from the hazard unit. When 1, IF/ID does not capture this cycle.
- Redirect  in  1  branch or jump taken; single-cycle pulse or level.
- RedirectTarget  in  32  new PC. Bits [1:0] are ignored and forced to 0.
- ImemReq  out  1  request to instruction memory.
- ImemAddr  out  32  word-aligned fetch address.
- ImemReady  in  1  ImemData is valid this cycle for the current request.
- ImemData  in  32  instruction word.
- FetchValid  out  1  FetchInstr and FetchPC are valid for IF/ID.
- FetchInstr  out  32  drives IF/ID InstructionIn.
- FetchPC  out  32  address of the fetched instruction + 4; drives IF/ID PCIn.
- FetchCount  out  32  count of instructions accepted by IF/ID.

## Operation
- Registers:
  - PC: address of the instruction currently being fetched or held.
  - HoldInstr: buffered instruction word.
  - PendTarget: saved redirect target.
  - state ∈ {FETCH, HOLD, DRAIN}.
  - FetchCount.
- Priority: Reset > Redirect > Stall.
- Reset (while asserted and in the following cycle's register values):
  - Register values: PC=RESET_PC, state=FETCH, HoldInstr=0, PendTarget=0, FetchCount=0.
  - While Reset=1, all outputs are forced to 0: ImemReq, FetchValid, FetchInstr, FetchPC.
- FETCH:
  - Outputs: ImemReq=1, ImemAddr=PC. FetchValid = ImemReady & !Redirect. FetchInstr=ImemData. FetchPC=PC+4.
  - ImemReady & !Redirect & !Stall: instruction accepted. PC<=PC+4, FetchCount++, stay FETCH.
  - ImemReady & !Redirect & Stall: HoldInstr<=ImemData, go to HOLD. PC unchanged.
  - ImemReady & Redirect: response discarded. PC<=RedirectTarget, stay FETCH.
  - !ImemReady & Redirect: PendTarget<=RedirectTarget, go to DRAIN.
  - !ImemReady & !Redirect: stay FETCH. Req and Addr are held stable.
- HOLD:
  - Outputs: ImemReq=0, FetchValid = !Redirect, FetchInstr=HoldInstr, FetchPC=PC+4.
  - Redirect: HoldInstr is dropped. PC<=RedirectTarget, go to FETCH.
  - !Stall: instruction accepted. PC<=PC+4, FetchCount++, go to FETCH.
  - Stall: stay HOLD. Outputs are unchanged.
- DRAIN (the outstanding wrong-path request must complete):
  - Outputs: ImemReq=1, ImemAddr=PC (the old address, held stable), FetchValid=0.
  - Redirect again: PendTarget<=RedirectTarget. The latest redirect wins.
  - ImemReady: data discarded. PC <= (Redirect ? RedirectTarget : PendTarget), go to FETCH.
  - Stall has no effect in DRAIN.
- Arithmetic:
  - PC+4 is modulo 2^32; 32'hFFFF_FFFC+4 = 0.
  - FetchCount wraps from 32'hFFFF_FFFF to 0.
- Stall while in FETCH with !ImemReady: the fetch continues. The decision is made on the ImemReady cycle.

## Timing
- ImemReq/ImemAddr and FetchValid/FetchInstr/FetchPC are combinational from state, registers, and the current inputs. No output depends combinationally on Stall.
- Best-case throughput: 1 instruction per cycle, with ImemReady high every cycle and Stall=0.
- Latency: from ImemReady in FETCH to IF/ID capture is 0 cycles (same edge) when Stall=0.
- Redirect penalty:
  - 0 extra cycles if it arrives in FETCH with ImemReady, or in HOLD. The next cycle fetches the target.
  - In DRAIN: the remaining wait for the old response, plus 1 cycle.
- Memory contract: ImemAddr never changes while ImemReq=1 and ImemReady=0.
- Reset mid-operation (HOLD/DRAIN): the next cycle is FETCH at RESET_PC. No pending data is delivered.

## Test plan
- Reset, RESET_PC=0, ImemReady=1, ImemData=PC-dependent word, Stall=0 for 4 cycles -> ImemAddr 0,4,8,C; FetchPC 4,8,C,10; FetchCount=4.
- ImemReady=1 at addr 8 with Stall=1 for 3 cycles -> HOLD. ImemReq=0, FetchInstr held at word(8), FetchPC=C each cycle. After Stall drops, next ImemAddr=C and FetchCount increments by exactly 1.
- Redirect=1 with RedirectTarget=32'h0000_0103 while ImemReady=1 at addr 4 -> FetchValid=0 that cycle; next ImemAddr=32'h0000_0100; FetchCount unchanged.
- ImemReady=0 at addr 10; Redirect to 40; 1 cycle later Redirect to 80; ImemReady rises 3 cycles later -> ImemAddr stays 10 throughout; FetchValid=0; next ImemAddr=80.
- RESET_PC=32'hFFFF_FFFC, one accepted fetch -> FetchPC=0, next ImemAddr=0.
- Reset asserted while in HOLD with Stall=1 -> FetchValid=0 during Reset; the next cycle has ImemAddr=RESET_PC and FetchCount=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequences the PC, handshakes with instruction memory,
// buffers one instruction across an ID stall and drains wrong-path responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic        FetchValid,
  output logic [31:0] FetchInstr,
  output logic [31:0] FetchPC,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign tgt        = RedirectTarget & ~32'h0000_0003;
  assign pc_inc     = pc_q + 32'd4;
  assign FetchCount = cnt_q;

  // Outputs never look at Stall, so the hazard unit can depend on FetchValid without a loop.
  always_comb begin
    ImemReq    = 1'b0;
    ImemAddr   = pc_q;
    FetchValid = 1'b0;
    FetchInstr = '0;
    FetchPC    = pc_inc;
    if (Reset) begin
      ImemAddr = '0;
      FetchPC  = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          ImemReq    = 1'b1;
          FetchValid = ImemReady & ~Redirect;
          FetchInstr = ImemData;
        end
        HOLD: begin
          FetchValid = ~Redirect;
          FetchInstr = hold_q;
        end
        DRAIN: begin
          ImemReq = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (Reset) begin
      state_d = FETCH;
      pc_d    = RESET_PC;
      hold_d  = '0;
      pend_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ImemReady) begin
            if (Redirect) begin
              pc_d = tgt;
            end else if (Stall) begin
              hold_d  = ImemData;
              state_d = HOLD;
            end else begin
              pc_d  = pc_inc;
              cnt_d = cnt_q + 32'd1;
            end
          end else if (Redirect) begin
            pend_d  = tgt;
            state_d = DRAIN;
          end
        end
        HOLD: begin
          if (Redirect) begin
            pc_d    = tgt;
            state_d = FETCH;
          end else if (!Stall) begin
            pc_d    = pc_inc;
            cnt_d   = cnt_q + 32'd1;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          // A redirect arriving on the completion cycle beats the saved target.
          if (Redirect) pend_d = tgt;
          if (ImemReady) begin
            pc_d    = Redirect ? tgt : pend_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    hold_q  <= hold_d;
    pend_q  <= pend_d;
    cnt_q   <= cnt_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a wrap-around instance, and random
// stimulus compared against a flag-based behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redir, rdy;
  logic [31:0] tgt, data, addr, finstr, fpc, fcnt;
  logic        req, fvalid;

  logic        r2_rst;
  logic        r2_req, r2_valid;
  logic [31:0] r2_addr, r2_data, r2_instr, r2_fpc, r2_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign data    = w(addr);
  assign r2_data = w(r2_addr);

  fetch_unit dut (
    .Clk(clk), .Reset(rst), .Stall(stall), .Redirect(redir), .RedirectTarget(tgt),
    .ImemReq(req), .ImemAddr(addr), .ImemReady(rdy), .ImemData(data),
    .FetchValid(fvalid), .FetchInstr(finstr), .FetchPC(fpc), .FetchCount(fcnt)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .Clk(clk), .Reset(r2_rst), .Stall(1'b0), .Redirect(1'b0), .RedirectTarget(32'h0),
    .ImemReq(r2_req), .ImemAddr(r2_addr), .ImemReady(1'b1), .ImemData(r2_data),
    .FetchValid(r2_valid), .FetchInstr(r2_instr), .FetchPC(r2_fpc), .FetchCount(r2_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] fpc, instr, cnt;
    logic        chk_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, s, d, input logic [31:0] t, input logic y,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] c, input logic cc);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = d; x.tgt = t; x.rdy = y;
    x.req = q; x.addr = a; x.valid = v; x.fpc = a + 32'd4; x.instr = w(a);
    x.cnt = c; x.chk_cnt = cc;
    return x;
  endfunction

  vec_t vecs[23];

  // Behavioural model: pc, an optional held word, an optional pending redirect.
  logic [31:0] m_pc, m_hold, m_pend, m_cnt;
  logic        m_has_hold, m_draining;

  task automatic apply_random(input logic r, s, d, input logic [31:0] t, input logic y);
    logic        e_req, e_valid;
    logic [31:0] e_instr, e_fpc;
    @(negedge clk);
    rst = r; stall = s; redir = d; tgt = t; rdy = y;
    #2;
    e_req = 1'b0; e_valid = 1'b0; e_instr = '0; e_fpc = '0;
    if (!r) begin
      e_fpc = m_pc + 32'd4;
      if (m_has_hold) begin
        e_valid = !d; e_instr = m_hold;
      end else if (m_draining) begin
        e_req = 1'b1;
      end else begin
        e_req = 1'b1; e_valid = y && !d; e_instr = w(m_pc);
      end
    end
    chk("req", {31'd0, req}, {31'd0, e_req});
    if (e_req) chk("addr", addr, m_pc);
    chk("valid", {31'd0, fvalid}, {31'd0, e_valid});
    if (e_valid || r) begin
      chk("fpc", fpc, e_fpc);
      chk("instr", finstr, e_instr);
    end
    chk("count", fcnt, m_cnt);
    if (r) begin
      m_pc = 32'h0; m_hold = '0; m_pend = '0; m_cnt = '0;
      m_has_hold = 1'b0; m_draining = 1'b0;
    end else if (m_has_hold) begin
      if (d) begin
        m_pc = t & ~32'h3; m_has_hold = 1'b0;
      end else if (!s) begin
        m_pc += 4; m_cnt++; m_has_hold = 1'b0;
      end
    end else if (m_draining) begin
      if (d) m_pend = t & ~32'h3;
      if (y) begin
        m_pc = m_pend; m_draining = 1'b0;
      end
    end else if (y) begin
      if (d) m_pc = t & ~32'h3;
      else if (s) begin
        m_has_hold = 1'b1; m_hold = w(m_pc);
      end else begin
        m_pc += 4; m_cnt++;
      end
    end else if (d) begin
      m_pend = t & ~32'h3; m_draining = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = '0; rdy = 1'b0;
    r2_rst = 1'b1;

    //            rst stl rdr tgt            rdy req addr          vld cnt cc
    vecs[0]  = mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 32'h0,          1, 1, 32'h0,          1, 0, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,          1, 1, 32'h4,          1, 1, 1);
    vecs[4]  = mk(0, 0, 0, 32'h0,          1, 1, 32'h8,          1, 2, 1);
    vecs[5]  = mk(0, 0, 0, 32'h0,          1, 1, 32'hC,          1, 3, 1);
    vecs[6]  = mk(0, 1, 0, 32'h0,          1, 1, 32'h10,         1, 4, 1);
    vecs[7]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h10,         1, 4, 1);
    vecs[8]  = mk(0, 1, 0, 32'h0,          1, 0, 32'h10,         1, 4, 1);
    vecs[9]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h10,         1, 4, 1);
    vecs[10] = mk(0, 0, 0, 32'h0,          1, 1, 32'h14,         1, 5, 1);
    vecs[11] = mk(0, 0, 1, 32'h103,        1, 1, 32'h18,         0, 6, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,          1, 1, 32'h100,        1, 6, 1);
    vecs[13] = mk(0, 0, 1, 32'h40,         0, 1, 32'h104,        0, 7, 1);
    vecs[14] = mk(0, 0, 1, 32'h80,         0, 1, 32'h104,        0, 7, 1);
    vecs[15] = mk(0, 1, 0, 32'h0,          0, 1, 32'h104,        0, 7, 1);
    vecs[16] = mk(0, 0, 0, 32'h0,          0, 1, 32'h104,        0, 7, 1);
    vecs[17] = mk(0, 0, 0, 32'h0,          1, 1, 32'h104,        0, 7, 1);
    vecs[18] = mk(0, 1, 0, 32'h0,          1, 1, 32'h80,         1, 7, 1);
    vecs[19] = mk(0, 1, 1, 32'h202,        0, 0, 32'h80,         0, 7, 1);
    vecs[20] = mk(0, 1, 0, 32'h0,          1, 1, 32'h200,        1, 7, 1);
    vecs[21] = mk(1, 1, 0, 32'h0,          1, 0, 32'h200,        0, 7, 1);
    vecs[22] = mk(0, 0, 0, 32'h0,          0, 1, 32'h0,          0, 0, 1);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; redir = vecs[i].redir;
      tgt = vecs[i].tgt; rdy = vecs[i].rdy;
      #2;
      chk($sformatf("v%0d.req", i), {31'd0, req}, {31'd0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("v%0d.addr", i), addr, vecs[i].addr);
      chk($sformatf("v%0d.valid", i), {31'd0, fvalid}, {31'd0, vecs[i].valid});
      if (vecs[i].valid) begin
        chk($sformatf("v%0d.fpc", i), fpc, vecs[i].fpc);
        chk($sformatf("v%0d.instr", i), finstr, vecs[i].instr);
      end
      if (vecs[i].rst) begin
        chk($sformatf("v%0d.rst_fpc", i), fpc, 32'h0);
        chk($sformatf("v%0d.rst_instr", i), finstr, 32'h0);
      end
      if (vecs[i].chk_cnt) chk($sformatf("v%0d.cnt", i), fcnt, vecs[i].cnt);
    end

    m_pc = 32'h0; m_hold = '0; m_pend = '0; m_cnt = '0;
    m_has_hold = 1'b0; m_draining = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      apply_random($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    r2_rst = 1'b0;
    #2;
    chk("wrap.addr", r2_addr, 32'hFFFF_FFFC);
    chk("wrap.valid", {31'd0, r2_valid}, 32'd1);
    chk("wrap.fpc", r2_fpc, 32'h0);
    chk("wrap.instr", r2_instr, w(32'hFFFF_FFFC));
    @(negedge clk);
    #2;
    chk("wrap.next_addr", r2_addr, 32'h0);
    chk("wrap.cnt", r2_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
